// File: rtl/conv_scheduler_pkg.sv
// Shared types and default sizes for the convolution read scheduler.
package conv_scheduler_pkg;

  localparam int def_array_size    = 9;
  localparam int def_dim_data_size = 8;
  localparam int def_addr_size     = 20;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/conv_addr_gen.sv
// oh/ow/kr window iterator; addresses are built from running bases so no multiplier is needed.
module conv_addr_gen
  import conv_scheduler_pkg::*;
#(
  parameter int dim_data_size = def_dim_data_size,
  parameter int addr_size     = def_addr_size
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init,
  input  logic                     advance,
  input  logic [addr_size-1:0]     base,
  input  logic [dim_data_size-1:0] w,
  input  logic [dim_data_size-1:0] kr_last,
  input  logic [dim_data_size-1:0] ow_last,
  input  logic [dim_data_size-1:0] oh_last,
  output logic [addr_size-1:0]     addr,
  output logic [dim_data_size-1:0] kr,
  output logic                     last
);

  logic [dim_data_size-1:0] ow, oh;
  // row_base = base + oh*W, col_base = row_base + ow, addr = col_base + kr*W
  logic [addr_size-1:0]     row_base, col_base;
  logic [addr_size-1:0]     w_ext;

  assign w_ext = addr_size'(w);
  assign last  = (kr == kr_last) && (ow == ow_last) && (oh == oh_last);

  always_ff @(posedge clk) begin
    if (!reset) begin
      kr       <= '0;
      ow       <= '0;
      oh       <= '0;
      row_base <= '0;
      col_base <= '0;
      addr     <= '0;
    end else if (init) begin
      kr       <= '0;
      ow       <= '0;
      oh       <= '0;
      row_base <= base;
      col_base <= base;
      addr     <= base;
    end else if (advance && !last) begin
      if (kr != kr_last) begin
        kr   <= kr + 1'b1;
        addr <= addr + w_ext;
      end else if (ow != ow_last) begin
        kr       <= '0;
        ow       <= ow + 1'b1;
        col_base <= col_base + 1'b1;
        addr     <= col_base + 1'b1;
      end else begin
        kr       <= '0;
        ow       <= '0;
        oh       <= oh + 1'b1;
        row_base <= row_base + w_ext;
        col_base <= row_base + w_ext;
        addr     <= row_base + w_ext;
      end
    end
  end

endmodule

// File: rtl/conv_scheduler.sv
// Job FSM for the systolic convolution: validates K/H/W, streams image reads, drains the array.
module conv_scheduler
  import conv_scheduler_pkg::*;
#(
  parameter int array_size    = def_array_size,
  parameter int dim_data_size = def_dim_data_size,
  parameter int addr_size     = def_addr_size
) (
  input  logic                     s_clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [dim_data_size-1:0] Weight_size,
  input  logic [dim_data_size-1:0] image_height,
  input  logic [dim_data_size-1:0] image_width,
  input  logic [addr_size-1:0]     initial_address,
  input  logic                     mem_ready,
  output logic [addr_size-1:0]     rd_addr,
  output logic                     rd_valid,
  output logic [dim_data_size-1:0] row_sel,
  output logic [array_size-1:0]    r_en,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [2:0]               fsm_state
);

  localparam logic [dim_data_size:0] array_size_w = (dim_data_size+1)'(array_size);
  localparam logic [dim_data_size:0] drain_base   = (dim_data_size+1)'(array_size - 2);

  state_t                   state, state_n;
  logic [dim_data_size-1:0] k_q, w_q, kr_last, ow_last, oh_last;
  logic [array_size-1:0]    mask_q, mask_in;
  logic [dim_data_size:0]   drain_cnt, drain_last;
  logic                     cfg_bad, advance, last;

  // Handshake: a read transfers on any rising edge where rd_valid && mem_ready;
  // rd_addr/row_sel stay fixed while rd_valid is high and mem_ready is low.
  assign advance    = rd_valid && mem_ready;
  assign drain_last = drain_base + {1'b0, k_q};
  assign fsm_state  = state;

  assign cfg_bad = (Weight_size == '0) || ({1'b0, Weight_size} > array_size_w) ||
                   (Weight_size > image_height) || (Weight_size > image_width);

  always_comb begin
    mask_in = '0;
    for (int i = 0; i < array_size; i++) mask_in[i] = (i < int'(Weight_size));
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = LOAD;
      LOAD:  state_n = cfg_bad ? DONE : FEED;
      FEED:  if (advance && last) state_n = DRAIN;
      DRAIN: if (drain_cnt == drain_last) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (!reset) begin
      state     <= IDLE;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      r_en      <= '0;
      k_q       <= '0;
      w_q       <= '0;
      kr_last   <= '0;
      ow_last   <= '0;
      oh_last   <= '0;
      mask_q    <= '0;
      drain_cnt <= '0;
    end else begin
      state    <= state_n;
      rd_valid <= (state_n == FEED);
      busy     <= (state_n != IDLE);
      done     <= (state_n == DONE);
      if ((state_n == FEED) || (state_n == DRAIN))
        r_en <= (state == LOAD) ? mask_in : mask_q;
      else
        r_en <= '0;
      // Configuration is captured only here, so it stays frozen for the whole job.
      if (state == LOAD) begin
        k_q     <= Weight_size;
        w_q     <= image_width;
        kr_last <= Weight_size - 1'b1;
        ow_last <= image_width - Weight_size;
        oh_last <= image_height - Weight_size;
        mask_q  <= mask_in;
      end
      if (state == IDLE && start) err <= 1'b0;
      if (state == LOAD && cfg_bad) err <= 1'b1;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  conv_addr_gen #(
    .dim_data_size(dim_data_size),
    .addr_size    (addr_size)
  ) u_addr_gen (
    .clk    (s_clk),
    .reset  (reset),
    .init   (state == LOAD),
    .advance(advance),
    .base   (initial_address),
    .w      (w_q),
    .kr_last(kr_last),
    .ow_last(ow_last),
    .oh_last(oh_last),
    .addr   (rd_addr),
    .kr     (row_sel),
    .last   (last)
  );

endmodule

// File: tb/tb_conv_scheduler.sv
// Directed bench for conv_scheduler: nominal, stall, illegal configs, wrap, reset abort, start-in-drain.
module tb_conv_scheduler;

  logic        s_clk = 1'b0;
  logic        reset, start, mem_ready;
  logic [7:0]  Weight_size, image_height, image_width;
  logic [19:0] initial_address;
  logic [19:0] rd_addr;
  logic        rd_valid, busy, done, err;
  logic [7:0]  row_sel;
  logic [8:0]  r_en;
  logic [2:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  always #5 s_clk = ~s_clk;

  conv_scheduler dut (
    .s_clk          (s_clk),
    .reset          (reset),
    .start          (start),
    .Weight_size    (Weight_size),
    .image_height   (image_height),
    .image_width    (image_width),
    .initial_address(initial_address),
    .mem_ready      (mem_ready),
    .rd_addr        (rd_addr),
    .rd_valid       (rd_valid),
    .row_sel        (row_sel),
    .r_en           (r_en),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .fsm_state      (fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference address from the direct formula: base + (oh+kr)*W + ow, mod 2^20.
  function automatic logic [19:0] exp_addr(input int idx, input int k, input int w,
                                           input logic [19:0] base);
    int ow_n, kr, ow, oh;
    ow_n = w - k + 1;
    kr   = idx % k;
    ow   = (idx / k) % ow_n;
    oh   = idx / (k * ow_n);
    return base + 20'((oh + kr) * w + ow);
  endfunction

  // Cycle numbering: c=1 is the LOAD cycle (start was sampled at the edge before it).
  task automatic run_job(input int k, input int h, input int w, input logic [19:0] base,
                         input int stall_idx, input int stall_len, input bit poke_drain,
                         output int reads, output int first_cyc, output int last_cyc,
                         output int done_cyc, output int drain_cyc, output int valid_cyc,
                         output logic [19:0] last_addr);
    int c, stalled, extra;
    bit poked, bad;
    logic [8:0] mask;
    bad       = (k == 0) || (k > 9) || (k > h) || (k > w);
    mask      = 9'((1 << k) - 1);
    reads     = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
    drain_cyc = 0; valid_cyc = 0; stalled = 0; poked = 0; last_addr = '0;
    @(negedge s_clk);
    Weight_size = 8'(k); image_height = 8'(h); image_width = 8'(w);
    initial_address = base; mem_ready = 1'b1; start = 1'b1;
    @(negedge s_clk);
    start = 1'b0;
    c = 1;
    check("load_state", 32'(fsm_state), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    check("load_err", 32'(err), 32'd0);
    while (done !== 1'b1 && c < 400) begin
      @(negedge s_clk);
      c++;
      start = 1'b0;
      if (fsm_state == 3'd3) begin
        drain_cyc++;
        if (poke_drain && !poked) begin start = 1'b1; poked = 1'b1; end
      end
      if (rd_valid) begin
        valid_cyc++;
        if (first_cyc < 0) first_cyc = c;
        check("rd_addr", 32'(rd_addr), 32'(exp_addr(reads, k, w, base)));
        check("row_sel", 32'(row_sel), 32'(reads % k));
        check("r_en_feed", 32'(r_en), 32'(mask));
        if (reads == stall_idx && stalled < stall_len) begin
          mem_ready = 1'b0;
          stalled++;
        end else begin
          mem_ready = 1'b1;
          last_addr = rd_addr;
          reads++;
          last_cyc = c;
        end
      end else begin
        mem_ready = 1'b1;
      end
      if (done === 1'b1) done_cyc = c;
    end
    check("done_seen", 32'(done), 32'd1);
    check("done_err", 32'(err), 32'(bad));
    check("done_rd_valid", 32'(rd_valid), 32'd0);
    start = 1'b0;
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge s_clk);
      if (done) extra++;
    end
    check("single_done", 32'(extra), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_state", 32'(fsm_state), 32'd0);
    check("idle_r_en", 32'(r_en), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_row_sel"}, 32'(row_sel), 32'd0);
    check({tag, "_r_en"}, 32'(r_en), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_state"}, 32'(fsm_state), 32'd0);
  endtask

  initial begin
    int reads, first_cyc, last_cyc, done_cyc, drain_cyc, valid_cyc, cnt;
    logic [19:0] last_addr;

    // Clock/reset
    reset = 1'b0; start = 1'b0; mem_ready = 1'b1;
    Weight_size = 8'd3; image_height = 8'd5; image_width = 8'd5; initial_address = '0;
    repeat (3) @(negedge s_clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    repeat (2) @(negedge s_clk);
    check("post_reset_idle", 32'(busy), 32'd0);

    // Nominal K=3 H=5 W=5: reads in cycles 2..28, 11 drain cycles, done in cycle 40
    run_job(3, 5, 5, 20'h0, -1, 0, 1'b0, reads, first_cyc, last_cyc, done_cyc, drain_cyc,
            valid_cyc, last_addr);
    check("nom_reads", 32'(reads), 32'd27);
    check("nom_first", 32'(first_cyc), 32'd2);
    check("nom_last", 32'(last_cyc), 32'd28);
    check("nom_drain", 32'(drain_cyc), 32'd11);
    check("nom_done", 32'(done_cyc), 32'd40);
    check("nom_last_addr", 32'(last_addr), 32'h16);

    // Second read stalled 4 cycles: everything shifts by 4
    run_job(3, 5, 5, 20'h0, 1, 4, 1'b0, reads, first_cyc, last_cyc, done_cyc, drain_cyc,
            valid_cyc, last_addr);
    check("stall_reads", 32'(reads), 32'd27);
    check("stall_valid_cycles", 32'(valid_cyc), 32'd31);
    check("stall_last", 32'(last_cyc), 32'd32);
    check("stall_done", 32'(done_cyc), 32'd44);

    // Illegal: K above array size, then K above H
    run_job(10, 12, 12, 20'h0, -1, 0, 1'b0, reads, first_cyc, last_cyc, done_cyc, drain_cyc,
            valid_cyc, last_addr);
    check("k10_valid", 32'(valid_cyc), 32'd0);
    check("k10_done", 32'(done_cyc), 32'd2);
    run_job(6, 5, 8, 20'h0, -1, 0, 1'b0, reads, first_cyc, last_cyc, done_cyc, drain_cyc,
            valid_cyc, last_addr);
    check("k6h5_valid", 32'(valid_cyc), 32'd0);
    check("k6h5_done", 32'(done_cyc), 32'd2);

    // Address wrap: FFFFE, FFFFF, 00000, 00001
    run_job(1, 1, 4, 20'hFFFFE, -1, 0, 1'b0, reads, first_cyc, last_cyc, done_cyc, drain_cyc,
            valid_cyc, last_addr);
    check("wrap_reads", 32'(reads), 32'd4);
    check("wrap_last_addr", 32'(last_addr), 32'h00001);
    check("wrap_drain", 32'(drain_cyc), 32'd9);
    check("wrap_done", 32'(done_cyc), 32'd15);

    // start pulsed during DRAIN is ignored
    run_job(3, 5, 5, 20'h0, -1, 0, 1'b1, reads, first_cyc, last_cyc, done_cyc, drain_cyc,
            valid_cyc, last_addr);
    check("poke_done", 32'(done_cyc), 32'd40);

    // Reset after the 10th accepted read
    @(negedge s_clk);
    Weight_size = 8'd3; image_height = 8'd5; image_width = 8'd5;
    initial_address = '0; mem_ready = 1'b1; start = 1'b1;
    @(negedge s_clk);
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50 && cnt < 10; i++) begin
      @(negedge s_clk);
      if (rd_valid && mem_ready) cnt++;
    end
    check("abort_reads", 32'(cnt), 32'd10);
    reset = 1'b0;
    @(negedge s_clk);
    check_reset_outputs("abort");
    reset = 1'b1;
    repeat (3) @(negedge s_clk);
    check("abort_stays_idle", 32'(busy), 32'd0);
    check("abort_no_valid", 32'(rd_valid), 32'd0);
    run_job(3, 5, 5, 20'h0, -1, 0, 1'b0, reads, first_cyc, last_cyc, done_cyc, drain_cyc,
            valid_cyc, last_addr);
    check("replay_reads", 32'(reads), 32'd27);
    check("replay_done", 32'(done_cyc), 32'd40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
